// File: rtl/req_encoder32_pkg.sv
// req_encoder32_pkg: shared CPU index constants and popcount helper for the request encoder.
package req_encoder32_pkg;
    localparam int N_REQ = 32;
    localparam int W_IDX = 5;

    typedef logic [W_IDX-1:0] idx_t;
    typedef logic [W_IDX:0]   cnt_t;

    function automatic cnt_t popcount(input logic [N_REQ-1:0] v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < N_REQ; i++)
            c = c + cnt_t'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/req_encoder32_prio_find32.sv
// prio_find32: combinational search for the first set bit at or after start, wrapping N-1 -> 0.
module prio_find32
    import req_encoder32_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = W_IDX
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [N-1:0] rot;
    logic [W-1:0] off;

    // rotate so that start lands at bit 0, then take the lowest set bit
    assign rot = N'({vec, vec} >> start);

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = W'(i);
    end

    assign idx = off + start;
    assign any = |vec;
endmodule

// File: rtl/req_encoder32.sv
// req_encoder32: sticky 32-to-5 request encoder issuing pending indices over valid/ready.
module req_encoder32
    import req_encoder32_pkg::*;
#(
    parameter int N           = N_REQ,
    parameter int W           = W_IDX,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    input  logic         out_ready,
    output logic [N-1:0] pend,
    output logic [W:0]   pend_cnt
);
    logic         load;
    logic         has;
    logic [W-1:0] sel;
    logic [W-1:0] ptr;
    logic [N-1:0] take;
    logic [N-1:0] pend_next;

    prio_find32 #(.N(N), .W(W)) u_find (
        .vec  (pend),
        .start(ROUND_ROBIN ? ptr : '0),
        .idx  (sel),
        .any  (has)
    );

    assign load      = !out_valid || out_ready;
    assign take      = load && has ? N'(1) << sel : '0;
    // new requests are OR-ed in after the clear so a same-edge set wins
    assign pend_next = (pend & ~take) | (en ? req : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= '0;
            pend_cnt  <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= popcount(pend_next);
            if (load) begin
                out_valid <= has;
                if (has) begin
                    out_idx <= sel;
                    ptr     <= sel + W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_req_encoder32.sv
// tb_req_encoder32: directed and random checks of fixed-priority and round-robin encoders against a set-based model.
module tb_req_encoder32;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req_v [2];
    logic        en_v  [2];
    logic        rdy_v [2];
    logic        val_v [2];
    logic [4:0]  idx_v [2];
    logic [31:0] pend_v[2];
    logic [5:0]  cnt_v [2];

    logic [31:0] mp [2];
    logic        mv [2];
    logic [4:0]  mi [2];
    int          mq [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_encoder32 #(.ROUND_ROBIN(1'b0)) u_fp (
        .clk(clk), .reset(reset), .req(req_v[0]), .en(en_v[0]),
        .out_valid(val_v[0]), .out_idx(idx_v[0]), .out_ready(rdy_v[0]),
        .pend(pend_v[0]), .pend_cnt(cnt_v[0])
    );

    req_encoder32 #(.ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .reset(reset), .req(req_v[1]), .en(en_v[1]),
        .out_valid(val_v[1]), .out_idx(idx_v[1]), .out_ready(rdy_v[1]),
        .pend(pend_v[1]), .pend_cnt(cnt_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            mp[u] = '0; mv[u] = 1'b0; mi[u] = '0; mq[u] = 0;
        end
    endtask

    // pending is a set of sources; the issuer scans it from a start position
    task automatic model_next(input int u);
        int  s;
        bit  found;
        logic [31:0] np;
        found = 0; s = 0;
        for (int k = 0; k < 32 && !found; k++) begin
            int j;
            j = ((u == 1 ? mq[u] : 0) + k) % 32;
            if (mp[u][j]) begin found = 1; s = j; end
        end
        np = mp[u];
        if (!mv[u] || rdy_v[u]) begin
            if (found) begin
                np[s] = 1'b0;
                mi[u] = 5'(s);
                mq[u] = (s + 1) % 32;
            end
            mv[u] = found;
        end
        if (en_v[u]) np = np | req_v[u];
        mp[u] = np;
    endtask

    task automatic compare();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d.out_valid", u), 32'(val_v[u]), 32'(mv[u]));
            chk($sformatf("u%0d.out_idx", u), 32'(idx_v[u]), 32'(mi[u]));
            chk($sformatf("u%0d.pend", u), pend_v[u], mp[u]);
            chk($sformatf("u%0d.pend_cnt", u), 32'(cnt_v[u]), 32'($countones(mp[u])));
        end
    endtask

    task automatic step();
        model_next(0);
        model_next(1);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drive(input int u, input logic [31:0] r, input logic e, input logic rd);
        req_v[u] = r; en_v[u] = e; rdy_v[u] = rd;
    endtask

    initial begin
        drive(0, '0, 1'b1, 1'b1);
        drive(1, '0, 1'b1, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        reset = 1'b0;

        // async reset with a full pending vector and a held output
        drive(0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();
        drive(0, '0, 1'b1, 1'b0);
        step();
        chk("rst.pre_valid", 32'(val_v[0]), 32'd1);
        chk("rst.pre_pend", pend_v[0], 32'hFFFF_FFFE);
        #2 reset = 1'b1;
        #1;
        chk("rst.valid", 32'(val_v[0]), 32'd0);
        chk("rst.idx", 32'(idx_v[0]), 32'd0);
        chk("rst.pend", pend_v[0], 32'd0);
        chk("rst.cnt", 32'(cnt_v[0]), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        step();
        chk("rst.after_valid", 32'(val_v[0]), 32'd0);

        // fixed priority order 0, 4, 31
        drive(0, 32'h8000_0011, 1'b1, 1'b1);
        step();
        chk("fp.cnt3", 32'(cnt_v[0]), 32'd3);
        chk("fp.valid0", 32'(val_v[0]), 32'd0);
        drive(0, '0, 1'b1, 1'b1);
        step();
        chk("fp.idx0", 32'(idx_v[0]), 32'd0);
        chk("fp.cnt2", 32'(cnt_v[0]), 32'd2);
        step();
        chk("fp.idx4", 32'(idx_v[0]), 32'd4);
        chk("fp.cnt1", 32'(cnt_v[0]), 32'd1);
        step();
        chk("fp.idx31", 32'(idx_v[0]), 32'd31);
        chk("fp.cnt0", 32'(cnt_v[0]), 32'd0);
        step();
        chk("fp.drained", 32'(val_v[0]), 32'd0);

        // backpressure holds the output stable
        drive(0, 32'h0000_0006, 1'b1, 1'b0);
        step();
        drive(0, '0, 1'b1, 1'b0);
        step();
        step();
        chk("bp.valid", 32'(val_v[0]), 32'd1);
        chk("bp.idx1", 32'(idx_v[0]), 32'd1);
        chk("bp.pend", pend_v[0], 32'h4);
        chk("bp.cnt", 32'(cnt_v[0]), 32'd1);
        rdy_v[0] = 1'b1;
        step();
        chk("bp.idx2", 32'(idx_v[0]), 32'd2);
        step();
        chk("bp.done", 32'(val_v[0]), 32'd0);

        // re-request of the held index merges into one extra issue
        drive(0, 32'h80, 1'b1, 1'b0);
        step();
        drive(0, '0, 1'b1, 1'b0);
        step();
        chk("col.idx7", 32'(idx_v[0]), 32'd7);
        drive(0, 32'h80, 1'b1, 1'b0);
        step();
        step();
        drive(0, '0, 1'b1, 1'b0);
        step();
        chk("col.pend", pend_v[0], 32'h80);
        chk("col.cnt", 32'(cnt_v[0]), 32'd1);
        rdy_v[0] = 1'b1;
        step();
        chk("col.reissue", 32'(idx_v[0]), 32'd7);
        chk("col.pend0", pend_v[0], 32'h0);
        step();
        chk("col.once", 32'(val_v[0]), 32'd0);

        // en gating drops requests but keeps draining
        drive(0, 32'h3, 1'b1, 1'b0);
        step();
        drive(0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step();
        chk("en.pend", pend_v[0], 32'h2);
        drive(0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step();
        chk("en.drain", 32'(idx_v[0]), 32'd1);
        step();
        chk("en.empty", 32'(val_v[0]), 32'd0);
        drive(0, '0, 1'b1, 1'b1);

        // rotating priority continues after the last issued index and wraps
        drive(1, 32'h20, 1'b1, 1'b1);
        step();
        drive(1, '0, 1'b1, 1'b1);
        step();
        chk("rr.idx5", 32'(idx_v[1]), 32'd5);
        drive(1, 32'h4000_0009, 1'b1, 1'b1);
        step();
        drive(1, '0, 1'b1, 1'b1);
        step();
        chk("rr.idx30", 32'(idx_v[1]), 32'd30);
        step();
        chk("rr.idx0", 32'(idx_v[1]), 32'd0);
        step();
        chk("rr.idx3", 32'(idx_v[1]), 32'd3);
        step();
        chk("rr.done", 32'(val_v[1]), 32'd0);

        // random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < 2; u++)
                drive(u, ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0,
                      $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
